// File: rtl/ir_receiver_if.sv
// Bundle between the IR receiver front-end and its consumer: raw demodulator
// input plus the decoded code word and its one-cycle strobes.
interface ir_receiver_if;
  logic        ir_in;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        ir_repeat;
  logic        ir_error;

  modport master (
    input  ir_in,
    output ir_data,
    output ir_valid,
    output ir_repeat,
    output ir_error
  );

  modport slave (
    output ir_in,
    input  ir_data,
    input  ir_valid,
    input  ir_repeat,
    input  ir_error
  );
endinterface

// File: rtl/ir_receiver.sv
// NEC pulse-distance decoder: synchronises the active-low IR line, times each
// level in ticks and publishes the low 16 bits of every good 32-bit frame.
module ir_receiver #(
  parameter int CLKS_PER_TICK = 7031
) (
  input  logic          clk,
  input  logic          reset_n,
  ir_receiver_if.master bus
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          hist_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    dur_q;
  state_t        state_q;
  logic [4:0]    bit_cnt_q;
  logic [31:0]   shift_q;
  logic [15:0]   data_q;
  logic          valid_q;
  logic          repeat_q;
  logic          error_q;
  logic          seen_q;

  logic          fall_d;
  logic          rise_d;
  logic          wrap_d;
  logic [7:0]    dur_d;
  logic [31:0]   shift_d;

  function automatic logic in_window(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign fall_d  = hist_q & ~sync2_q;
  assign rise_d  = ~hist_q & sync2_q;
  assign wrap_d  = (presc_q == PRESC_LAST);
  // Counting the wrap of the current cycle makes a level of exactly N ticks read as N.
  assign dur_d   = (wrap_d && (dur_q != 8'hFF)) ? dur_q + 8'd1 : dur_q;
  assign shift_d = {shift_q[30:0], (dur_d >= 8'd9)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      sync1_q <= bus.ir_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (fall_d || rise_d) begin
        presc_q <= '0;
        dur_q   <= '0;
      end else begin
        presc_q <= wrap_d ? '0 : presc_q + PW'(1);
        dur_q   <= dur_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      error_q   <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      error_q  <= 1'b0;
      if ((state_q != IDLE) && (dur_d >= 8'd128)) begin
        error_q <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (fall_d) state_q <= LEAD_MARK;
          LEAD_MARK: if (rise_d) begin
            if (in_window(dur_d, 8'd48, 8'd80)) begin
              state_q <= LEAD_SPACE;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          LEAD_SPACE: if (fall_d) begin
            if (in_window(dur_d, 8'd24, 8'd40)) begin
              bit_cnt_q <= '0;
              shift_q   <= '0;
              state_q   <= BIT_MARK;
            end else if (in_window(dur_d, 8'd12, 8'd20)) begin
              repeat_q <= seen_q;
              state_q  <= STOP_MARK;
            end else begin
              error_q <= 1'b1;
              state_q <= LEAD_MARK;
            end
          end
          BIT_MARK: if (rise_d) begin
            if (in_window(dur_d, 8'd2, 8'd6)) begin
              state_q <= BIT_SPACE;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          BIT_SPACE: if (fall_d) begin
            if (in_window(dur_d, 8'd2, 8'd6) || in_window(dur_d, 8'd9, 8'd15)) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 5'd31) begin
                data_q  <= shift_d[15:0];
                valid_q <= 1'b1;
                seen_q  <= 1'b1;
                state_q <= STOP_MARK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
                state_q   <= BIT_MARK;
              end
            end else begin
              error_q <= 1'b1;
              state_q <= LEAD_MARK;
            end
          end
          STOP_MARK: if (rise_d) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ir_data   = data_q;
  assign bus.ir_valid  = valid_q;
  assign bus.ir_repeat = repeat_q;
  assign bus.ir_error  = error_q;

endmodule
